// File: rtl/plru_set_replacer.sv
// Tree-PLRU replacement state for a multi-set cache.
// Each set stores a (WAYS-1)-bit heap-ordered PLRU tree and a per-way valid
// vector. Hits and fills touch the tree. Victim queries return a registered
// result that prefers the lowest invalid way over the PLRU walk. A flush
// engine clears one set per cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | normal operation: touches, fills and victim queries are serviced
// ST_FLUSH | flush_cnt_q walks sets 0..SETS-1, clearing one set per cycle
module plru_set_replacer #(
  parameter int WAY_BITS = 2,
  parameter int SET_BITS = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       access_valid,
  input  logic [((SET_BITS > 0) ? SET_BITS : 1)-1:0] access_set,
  input  logic [WAY_BITS-1:0]                        access_way,
  input  logic                                       fill_valid,
  input  logic [((SET_BITS > 0) ? SET_BITS : 1)-1:0] fill_set,
  input  logic [WAY_BITS-1:0]                        fill_way,
  input  logic                                       victim_req,
  input  logic [((SET_BITS > 0) ? SET_BITS : 1)-1:0] victim_set,
  output logic                                       victim_valid,
  output logic [WAY_BITS-1:0]                        victim_way,
  input  logic                                       flush_req,
  output logic                                       flush_busy
);

  localparam int WAYS  = 1 << WAY_BITS;
  localparam int SETS  = 1 << SET_BITS;
  localparam int SIDX  = (SET_BITS > 0) ? SET_BITS : 1;
  localparam int NODES = WAYS - 1;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_t;

  // Tree node n (heap numbering, root = 1) lives in bit n-1.
  logic [NODES-1:0]    tree_q  [SETS];
  logic [NODES-1:0]    tree_d  [SETS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     valid_d [SETS];

  state_t              state_q, state_d;
  logic [SIDX-1:0]     flush_cnt_q, flush_cnt_d;
  logic                victim_valid_q, victim_valid_d;
  logic [WAY_BITS-1:0] victim_way_q, victim_way_d;

  logic [SIDX-1:0]     access_idx;
  logic [SIDX-1:0]     fill_idx;
  logic [SIDX-1:0]     victim_idx;
  logic                same_set;

  // With a single set the set inputs carry no information and are forced to 0.
  function automatic logic [SIDX-1:0] set_index(input logic [SIDX-1:0] s);
    logic [SIDX-1:0] idx;
    idx = s;
    if (SET_BITS == 0) begin
      idx = '0;
    end
    return idx;
  endfunction

  // Point every node on the root-to-way path away from the touched way.
  // Node k at depth d lies on the path when the top d bits of the way equal k.
  function automatic logic [NODES-1:0] plru_touch(
    input logic [NODES-1:0]    tree,
    input logic [WAY_BITS-1:0] way
  );
    logic [NODES-1:0] t;
    t = tree;
    for (int d = 0; d < WAY_BITS; d++) begin
      for (int k = 0; k < (1 << d); k++) begin
        if ((int'(way) >> (WAY_BITS - d)) == k) begin
          t[(1 << d) + k - 1] = ~way[WAY_BITS-1-d];
        end
      end
    end
    return t;
  endfunction

  // A leaf is reached by the walk when every node on its path points toward it.
  // Exactly one leaf satisfies this for any tree value.
  function automatic logic [WAY_BITS-1:0] plru_walk(input logic [NODES-1:0] tree);
    logic [WAY_BITS-1:0] way;
    logic                hit;
    logic                dir;
    way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit = 1'b1;
      for (int d = 0; d < WAY_BITS; d++) begin
        dir = 1'((w >> (WAY_BITS - 1 - d)) & 1);
        if (tree[(1 << d) + (w >> (WAY_BITS - d)) - 1] != dir) begin
          hit = 1'b0;
        end
      end
      if (hit) begin
        way = WAY_BITS'(w);
      end
    end
    return way;
  endfunction

  // Lowest invalid way wins; a fully valid set falls back to the PLRU walk.
  function automatic logic [WAY_BITS-1:0] pick_victim(
    input logic [NODES-1:0] tree,
    input logic [WAYS-1:0]  valid
  );
    logic [WAY_BITS-1:0] way;
    way = plru_walk(tree);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        way = WAY_BITS'(w);
      end
    end
    return way;
  endfunction

  assign access_idx = set_index(access_set);
  assign fill_idx   = set_index(fill_set);
  assign victim_idx = set_index(victim_set);
  assign same_set   = fill_valid && (fill_idx == access_idx);

  // Next-state: set updates, victim lookup and flush sequencing.
  always_comb begin
    tree_d         = tree_q;
    valid_d        = valid_q;
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    victim_valid_d = 1'b0;
    victim_way_d   = victim_way_q;

    case (state_q)
      ST_IDLE: begin
        // A fill to the same set owns the tree this cycle; the hit is dropped.
        if (access_valid && !same_set) begin
          tree_d[access_idx] = plru_touch(tree_q[access_idx], access_way);
        end
        if (fill_valid) begin
          tree_d[fill_idx]           = plru_touch(tree_q[fill_idx], fill_way);
          valid_d[fill_idx][fill_way] = 1'b1;
        end
        // Lookup reads pre-edge state; same-cycle updates are not forwarded.
        if (victim_req) begin
          victim_valid_d = 1'b1;
          victim_way_d   = pick_victim(tree_q[victim_idx], valid_q[victim_idx]);
        end
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end

      ST_FLUSH: begin
        tree_d[flush_cnt_q]  = '0;
        valid_d[flush_cnt_q] = '0;
        if (flush_cnt_q == SIDX'(SETS - 1)) begin
          state_d     = ST_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        flush_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset clears every set and aborts any flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s]  <= '0;
        valid_q[s] <= '0;
      end
      state_q        <= ST_IDLE;
      flush_cnt_q    <= '0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s]  <= tree_d[s];
        valid_q[s] <= valid_d[s];
      end
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;
  assign flush_busy   = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_plru_set_replacer.sv
// Directed and randomized checks of plru_set_replacer against a per-node
// array model of the PLRU trees and per-way valid flags.
module tb_plru_set_replacer;

  localparam int WB   = 2;
  localparam int SB   = 4;
  localparam int WAYS = 1 << WB;
  localparam int SETS = 1 << SB;

  logic          clk;
  logic          rst;
  logic          access_valid;
  logic [SB-1:0] access_set;
  logic [WB-1:0] access_way;
  logic          fill_valid;
  logic [SB-1:0] fill_set;
  logic [WB-1:0] fill_way;
  logic          victim_req;
  logic [SB-1:0] victim_set;
  logic          victim_valid;
  logic [WB-1:0] victim_way;
  logic          flush_req;
  logic          flush_busy;

  int errors = 0;
  int checks = 0;

  // Reference model: node values indexed by heap number (1..WAYS-1).
  int m_tree  [SETS][WAYS];
  bit m_valid [SETS][WAYS];
  bit m_busy;
  int m_cnt;

  plru_set_replacer #(.WAY_BITS(WB), .SET_BITS(SB)) dut (
    .clk          (clk),
    .rst          (rst),
    .access_valid (access_valid),
    .access_set   (access_set),
    .access_way   (access_way),
    .fill_valid   (fill_valid),
    .fill_set     (fill_set),
    .fill_way     (fill_way),
    .victim_req   (victim_req),
    .victim_set   (victim_set),
    .victim_valid (victim_valid),
    .victim_way   (victim_way),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_tree[s][w]  = 0;
        m_valid[s][w] = 0;
      end
    end
    m_busy = 0;
    m_cnt  = 0;
  endfunction

  function automatic void m_touch(int s, int w);
    int node;
    int b;
    node = 1;
    for (int d = 0; d < WB; d++) begin
      b = (w >> (WB - 1 - d)) & 1;
      m_tree[s][node] = 1 - b;
      node = 2 * node + b;
    end
  endfunction

  function automatic int m_victim(int s);
    int node;
    int way;
    for (int w = 0; w < WAYS; w++) begin
      if (!m_valid[s][w]) return w;
    end
    node = 1;
    way  = 0;
    for (int d = 0; d < WB; d++) begin
      way  = way * 2 + m_tree[s][node];
      node = 2 * node + m_tree[s][node];
    end
    return way;
  endfunction

  task automatic clear_inputs();
    access_valid = 0; access_set = '0; access_way = '0;
    fill_valid   = 0; fill_set   = '0; fill_way   = '0;
    victim_req   = 0; victim_set = '0;
    flush_req    = 0;
  endtask

  // One clock with the currently driven inputs; checks outputs against the model.
  task automatic cyc();
    logic          exp_v;
    logic [WB-1:0] exp_w;
    exp_v = victim_req && !m_busy;
    exp_w = exp_v ? WB'(m_victim(int'(victim_set))) : '0;
    @(posedge clk);
    #1;
    if (m_busy) begin
      for (int w = 0; w < WAYS; w++) begin
        m_tree[m_cnt][w]  = 0;
        m_valid[m_cnt][w] = 0;
      end
      m_cnt++;
      if (m_cnt == SETS) begin
        m_busy = 0;
        m_cnt  = 0;
      end
    end else begin
      if (access_valid && !(fill_valid && fill_set == access_set))
        m_touch(int'(access_set), int'(access_way));
      if (fill_valid) begin
        m_touch(int'(fill_set), int'(fill_way));
        m_valid[fill_set][fill_way] = 1;
      end
      if (flush_req) begin
        m_busy = 1;
        m_cnt  = 0;
      end
    end
    checks++;
    assert (victim_valid === exp_v) else begin
      errors++;
      $error("FAIL victim_valid: got %0b expected %0b", victim_valid, exp_v);
    end
    if (exp_v) begin
      checks++;
      assert (victim_way === exp_w) else begin
        errors++;
        $error("FAIL victim_way(model) set %0d: got %0d expected %0d", victim_set, victim_way, exp_w);
      end
    end
    checks++;
    assert (flush_busy === m_busy) else begin
      errors++;
      $error("FAIL flush_busy: got %0b expected %0b", flush_busy, m_busy);
    end
    clear_inputs();
  endtask

  task automatic do_fill(int s, int w);
    fill_valid = 1; fill_set = SB'(s); fill_way = WB'(w);
    cyc();
  endtask

  task automatic do_touch(int s, int w);
    access_valid = 1; access_set = SB'(s); access_way = WB'(w);
    cyc();
  endtask

  task automatic query(int s, int exp);
    logic [WB-1:0] e;
    e = WB'(exp);
    victim_req = 1; victim_set = SB'(s);
    cyc();
    checks++;
    assert (victim_way === e) else begin
      errors++;
      $error("FAIL victim_way(directed) set %0d: got %0d expected %0d", s, victim_way, e);
    end
  endtask

  initial begin
    int n;
    clk = 0;
    rst = 1;
    clear_inputs();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (victim_valid === 1'b0) else begin
      errors++; $error("FAIL reset victim_valid: got %0b expected 0", victim_valid);
    end
    checks++;
    assert (victim_way === '0) else begin
      errors++; $error("FAIL reset victim_way: got %0d expected 0", victim_way);
    end
    checks++;
    assert (flush_busy === 1'b0) else begin
      errors++; $error("FAIL reset flush_busy: got %0b expected 0", flush_busy);
    end
    rst = 0;

    query(3, 0);

    for (int w = 0; w < WAYS; w++) do_fill(5, w);
    query(5, 0);
    do_touch(5, 0); query(5, 2);
    do_touch(5, 2); query(5, 1);
    do_touch(5, 1); query(5, 3);

    do_fill(2, 0); do_fill(2, 1); do_fill(2, 3);
    query(2, 2);
    do_fill(2, 2);
    query(2, 0);
    query(4, 0);

    // Same-set fill and hit: only the fill touch lands.
    do_touch(5, 3);
    for (int w = 0; w < WAYS; w++) do_fill(6, w);
    fill_valid = 1; fill_set = 5; fill_way = 1;
    access_valid = 1; access_set = 5; access_way = 3;
    cyc();
    query(5, 2);
    // Different sets: both touches land.
    fill_valid = 1; fill_set = 5; fill_way = 2;
    access_valid = 1; access_set = 6; access_way = 0;
    cyc();
    query(5, 0);
    query(6, 2);

    // Back-to-back queries plus a same-cycle fill that must not be forwarded.
    victim_req = 1; victim_set = 5; cyc();
    victim_req = 1; victim_set = 6; fill_valid = 1; fill_set = 6; fill_way = 3; cyc();
    victim_req = 1; victim_set = 6; cyc();
    victim_req = 1; victim_set = 2; cyc();

    // Full flush with victim requests during it.
    flush_req = 1; victim_req = 1; victim_set = 5;
    cyc();
    n = 0;
    while (flush_busy === 1'b1 && n < 40) begin
      n++;
      victim_req = 1; victim_set = SB'(n);
      cyc();
    end
    checks++;
    assert (n == SETS) else begin
      errors++; $error("FAIL flush_length: got %0d expected %0d", n, SETS);
    end
    for (int s = 0; s < SETS; s++) query(s, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 500; i++) begin
      access_valid = 1'($urandom_range(0, 1));
      access_set   = SB'($urandom_range(0, 3));
      access_way   = WB'($urandom_range(0, WAYS - 1));
      fill_valid   = ($urandom_range(0, 2) == 0);
      fill_set     = SB'($urandom_range(0, 3));
      fill_way     = WB'($urandom_range(0, WAYS - 1));
      victim_req   = 1'($urandom_range(0, 1));
      victim_set   = SB'($urandom_range(0, 3));
      flush_req    = ($urandom_range(0, 79) == 0);
      cyc();
    end
    n = 0;
    while (m_busy && n < 40) begin
      n++;
      cyc();
    end

    // Reset in the middle of a flush.
    for (int w = 0; w < WAYS; w++) do_fill(1, w);
    flush_req = 1;
    cyc();
    repeat (7) cyc();
    #2 rst = 1;
    #1;
    checks++;
    assert (flush_busy === 1'b0) else begin
      errors++; $error("FAIL midflush_reset flush_busy: got %0b expected 0", flush_busy);
    end
    checks++;
    assert (victim_valid === 1'b0) else begin
      errors++; $error("FAIL midflush_reset victim_valid: got %0b expected 0", victim_valid);
    end
    m_reset();
    @(negedge clk);
    rst = 0;
    query(9, 0);
    query(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
